// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight writers, load-use/RAW/branch/memory-wait control, stall counter.
// Optional forwarding select outputs (fwd_a/fwd_b) and removal of the RAW stall are enabled with `define HAZ_FWD_EN.
module hazard_ctrl #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            D_valid,
    input  logic [RA_W-1:0] D_rs1,
    input  logic [RA_W-1:0] D_rs2,
    input  logic            D_use_rs1,
    input  logic            D_use_rs2,
    input  logic [RA_W-1:0] D_rd,
    input  logic            D_we,
    input  logic            D_ld,
    input  logic            D_str,
    input  logic            EX_brn_taken,
    input  logic            mem_ready,
    output logic            stall_F,
    output logic            hold_D,
    output logic            flush_D,
    output logic            stall_D,
    output logic            freeze,
    output logic [1:0]      hz_state,
    output logic [XLEN-1:0] stall_cnt
`ifdef HAZ_FWD_EN
    ,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
`endif
);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
        logic            str;
    } slot_t;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_DATA    = 2'd1,
        HZ_FLUSH   = 2'd2,
        HZ_MEMWAIT = 2'd3
    } hz_e;

    slot_t           ex_q, ex_d, mem_q, mem_d;
    hz_e             hz_q, hz_d;
    logic [XLEN-1:0] cnt_q, cnt_d;

    logic memwait, branch, lduse, raw;
    logic ex_m1, ex_m2, mem_m1, mem_m2;

    function automatic logic slot_match(input slot_t s, input logic use_f,
                                        input logic [RA_W-1:0] rs);
        return s.v && s.we && (s.rd != '0) && use_f && (rs == s.rd);
    endfunction

    assign ex_m1  = slot_match(ex_q,  D_use_rs1, D_rs1);
    assign ex_m2  = slot_match(ex_q,  D_use_rs2, D_rs2);
    assign mem_m1 = slot_match(mem_q, D_use_rs1, D_rs1);
    assign mem_m2 = slot_match(mem_q, D_use_rs2, D_rs2);

    assign memwait = mem_q.v && (mem_q.ld || mem_q.str) && !mem_ready;
    assign branch  = EX_brn_taken;
    assign lduse   = D_valid && ex_q.ld && (ex_m1 || ex_m2);
`ifdef HAZ_FWD_EN
    assign raw     = 1'b0;
`else
    assign raw     = D_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall_F = 1'b0;
        hold_D  = 1'b0;
        flush_D = 1'b0;
        stall_D = 1'b0;
        freeze  = 1'b0;
        hz_d    = HZ_RUN;

        if (memwait) begin
            freeze  = 1'b1;
            stall_F = 1'b1;
            hold_D  = 1'b1;
            hz_d    = HZ_MEMWAIT;
        end else if (branch) begin
            // The decode instruction is wrong-path, so any data hazard it has is irrelevant.
            flush_D = 1'b1;
            stall_D = 1'b1;
            hz_d    = HZ_FLUSH;
        end else if (lduse || raw) begin
            stall_D = 1'b1;
            stall_F = 1'b1;
            hold_D  = 1'b1;
            hz_d    = HZ_DATA;
        end

        mem_d = mem_q;
        ex_d  = ex_q;
        if (!freeze) begin
            mem_d = ex_q;
            ex_d  = stall_D ? '0 : slot_t'{D_valid, D_rd, D_we, D_ld, D_str};
        end

        cnt_d = cnt_q;
        if ((stall_F || stall_D) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            hz_q  <= HZ_RUN;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            hz_q  <= hz_d;
            cnt_q <= cnt_d;
        end
    end

    assign hz_state  = hz_q;
    assign stall_cnt = cnt_q;

`ifdef HAZ_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // The EX/MEM result is younger than MEM/WB, so an EX-slot hit wins.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!stall_D && !freeze) begin
            fwd_a_d = ex_m1 ? 2'b01 : (mem_m1 ? 2'b10 : 2'b00);
            fwd_b_d = ex_m2 ? 2'b01 : (mem_m2 ? 2'b10 : 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; control vector is {stall_F, hold_D, flush_D, stall_D, freeze}.
// Expectations cover both the default build and the HAZ_FWD_EN build.
module tb_hazard_ctrl;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_DATA  = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_MWAIT = 5'b11001;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            D_valid, D_use_rs1, D_use_rs2, D_we, D_ld, D_str;
    logic [RA_W-1:0] D_rs1, D_rs2, D_rd;
    logic            EX_brn_taken, mem_ready;
    logic            stall_F, hold_D, flush_D, stall_D, freeze;
    logic [1:0]      hz_state;
    logic [XLEN-1:0] stall_cnt;
`ifdef HAZ_FWD_EN
    logic [1:0]      fwd_a, fwd_b;
`endif
    logic [4:0]      ctl;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    assign ctl = {stall_F, hold_D, flush_D, stall_D, freeze};

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_valid(D_valid), .D_rs1(D_rs1), .D_rs2(D_rs2),
        .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .D_rd(D_rd), .D_we(D_we), .D_ld(D_ld), .D_str(D_str),
        .EX_brn_taken(EX_brn_taken), .mem_ready(mem_ready),
        .stall_F(stall_F), .hold_D(hold_D), .flush_D(flush_D),
        .stall_D(stall_D), .freeze(freeze),
        .hz_state(hz_state), .stall_cnt(stall_cnt)
`ifdef HAZ_FWD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive decode fields, then settle the combinational outputs before checking.
    task automatic issue(input logic v, input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                         input logic u1, input logic u2, input logic [RA_W-1:0] rd,
                         input logic we, input logic ld, input logic st);
        D_valid = v; D_rs1 = rs1; D_rs2 = rs2; D_use_rs1 = u1; D_use_rs2 = u2;
        D_rd = rd; D_we = we; D_ld = ld; D_str = st;
        #1;
    endtask

    task automatic drain();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EX_brn_taken = 1'b0; mem_ready = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_IDLE); end
        total++;
        if (hz_state !== 2'd0) begin bad++; $display("FAIL reset_hz got=%0d want=0", hz_state); end
        total++;
        if (stall_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // ld x5
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL lduse_issue got=%b want=%b", ctl, C_IDLE); end
        step();
        issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6, x5
        total++;
        if (ctl !== C_DATA) begin bad++; $display("FAIL lduse_ctl got=%b want=%b", ctl, C_DATA); end
        step();
        exp_cnt++;
        total++;
        if (hz_state !== 2'd1) begin bad++; $display("FAIL lduse_hz got=%0d want=1", hz_state); end
`ifdef HAZ_FWD_EN
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL lduse_release got=%b want=%b", ctl, C_IDLE); end
        step();
        total++;
        if (fwd_a !== 2'b10) begin bad++; $display("FAIL lduse_fwd_a got=%b want=10", fwd_a); end
`else
        total++;
        if (ctl !== C_DATA) begin bad++; $display("FAIL lduse_raw_mem got=%b want=%b", ctl, C_DATA); end
        step();
        exp_cnt++;
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL lduse_release got=%b want=%b", ctl, C_IDLE); end
        step();
`endif
        total++;
        if (hz_state !== 2'd0) begin bad++; $display("FAIL lduse_hz_run got=%0d want=0", hz_state); end
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lduse_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_branch();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // ld x5
        step();
        EX_brn_taken = 1'b1;
        issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);   // wrong-path writer of x9
        total++;
        if (ctl !== C_FLUSH) begin bad++; $display("FAIL branch_ctl got=%b want=%b", ctl, C_FLUSH); end
        step();
        exp_cnt++;
        EX_brn_taken = 1'b0;
        total++;
        if (hz_state !== 2'd2) begin bad++; $display("FAIL branch_hz got=%0d want=2", hz_state); end
        // A reader of x9 must not stall: the flushed writer was replaced by a bubble.
        issue(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL branch_bubble got=%b want=%b", ctl, C_IDLE); end
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL branch_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_memwait();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);   // store
        step();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
        step();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== C_MWAIT) begin bad++; $display("FAIL memwait_ctl[%0d] got=%b want=%b", i, ctl, C_MWAIT); end
            step();
            exp_cnt++;
        end
        total++;
        if (hz_state !== 2'd3) begin bad++; $display("FAIL memwait_hz got=%0d want=3", hz_state); end
        mem_ready = 1'b1;
        // add x3 must still be in the EX slot after the freeze.
        issue(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZ_FWD_EN
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL memwait_release got=%b want=%b", ctl, C_IDLE); end
        step();
        total++;
        if (fwd_a !== 2'b01) begin bad++; $display("FAIL memwait_fwd_a got=%b want=01", fwd_a); end
`else
        total++;
        if (ctl !== C_DATA) begin bad++; $display("FAIL memwait_ex_kept got=%b want=%b", ctl, C_DATA); end
        step();
        exp_cnt++;
`endif
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL memwait_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_x0_nouse();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // ld into x0
        step();
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL x0_reader got=%b want=%b", ctl, C_IDLE); end
        step();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);   // ld x7
        step();
        issue(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL nouse_reader got=%b want=%b", ctl, C_IDLE); end
        step();
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL x0_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_raw();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
        step();
        issue(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // reader of rs2=x3
`ifdef HAZ_FWD_EN
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL raw_fwd_ctl got=%b want=%b", ctl, C_IDLE); end
        step();
        total++;
        if (fwd_b !== 2'b01) begin bad++; $display("FAIL raw_fwd_b got=%b want=01", fwd_b); end
`else
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ctl !== C_DATA) begin bad++; $display("FAIL raw_stall[%0d] got=%b want=%b", i, ctl, C_DATA); end
            step();
            exp_cnt++;
        end
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL raw_issue got=%b want=%b", ctl, C_IDLE); end
        step();
`endif
        total++;
        if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL raw_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_reset_midstall();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // ld x5
        step();
        issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        total++;
        if (ctl !== C_DATA) begin bad++; $display("FAIL midrst_pre got=%b want=%b", ctl, C_DATA); end
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL midrst_ctl got=%b want=%b", ctl, C_IDLE); end
        total++;
        if (stall_cnt !== 0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", stall_cnt); end
        rst_n = 1'b1;
        step();
        total++;
        if (ctl !== C_IDLE) begin bad++; $display("FAIL midrst_after got=%b want=%b", ctl, C_IDLE); end
        total++;
        if (hz_state !== 2'd0) begin bad++; $display("FAIL midrst_hz got=%0d want=0", hz_state); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_memwait();
        test_x0_nouse();
        test_raw();
        test_reset_midstall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; generates the stall and flush controls consumed by the F->D and D->EX pipeline registers.
- Drives the stall_D input of the D->EX register: stall_D high inserts a zero bubble into EX.
- Keeps an internal scoreboard of in-flight destination registers (EX and MEM slots), built from the decode-stage fields as they issue.
- Detects load-use and RAW hazards, handles branch-taken flush and the data-memory wait freeze, and counts stall cycles.

Parameters:
- XLEN, 32, datapath width; sets the width of the stall counter.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- D_valid  in  1  decode holds a real instruction
- D_rs1  in  RA_W  source reg 1
- D_rs2  in  RA_W  source reg 2
- D_use_rs1  in  1  instruction reads rs1
- D_use_rs2  in  1  instruction reads rs2
- D_rd  in  RA_W  destination reg
- D_we  in  1  register write enable
- D_ld  in  1  load
- D_str  in  1  store
- EX_brn_taken  in  1  branch in EX resolved taken
- mem_ready  in  1  data memory completes the access in MEM this cycle
- stall_F  out  1  hold PC
- hold_D  out  1  hold the F->D register
- flush_D  out  1  zero the F->D register
- stall_D  out  1  bubble into the D->EX register
- freeze  out  1  hold every pipeline register (EX, MEM, WB)
- hz_state  out  2  registered stall cause of the previous cycle
- stall_cnt  out  XLEN  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0):
  - Both scoreboard slots invalid; hz_state=RUN(0); stall_cnt=0.
  - Outputs are then combinational from the cleared state: all stall/flush outputs 0.
- Scoreboard:
  - Each slot holds {v, rd, we, ld, str}.
  - Each clock with freeze=0: mem_slot <= ex_slot.
  - ex_slot <= bubble (v=0) if stall_D, else {D_valid, D_rd, D_we, D_ld, D_str}.
  - With freeze=1, both slots hold.
- Match rule: a slot matches a source when all of these hold: slot v, slot we, rd != 0, use flag set, and rs == rd.
- Combinational hazard terms (same cycle as the D inputs):
  - memwait = mem_slot.v & (mem_slot.ld | mem_slot.str) & ~mem_ready.
  - branch = EX_brn_taken.
  - lduse = D_valid & ex_slot.ld & (ex_slot matches rs1 or rs2).
  - raw (only without HAZ_FWD_EN): D_valid & (ex_slot or mem_slot matches rs1 or rs2).
- Priority, highest first:
  1. memwait: freeze=1, stall_F=1, hold_D=1; stall_D=0, flush_D=0. The bubble logic is suppressed so the EX contents are preserved.
  2. branch: flush_D=1, stall_D=1; stall_F=0, so the PC loads the target. A load-use in the same cycle is discarded, because the D instruction is wrong-path.
  3. lduse or raw: stall_D=1, stall_F=1, hold_D=1.
  4. Otherwise: all outputs 0.
- hz_state: registered cause of the prior cycle, encoded 0 RUN, 1 DATA (lduse/raw), 2 FLUSH, 3 MEMWAIT. Updates every clock, including while frozen.
- Stall counting:
  - stall_cnt increments when stall_F or stall_D is 1.
  - A cycle that asserts both counts once.
  - Saturates at all-ones; no wrap.
- Load-use cannot repeat back-to-back for the same pair: after the bubble, ex_slot is invalid and the load sits in mem_slot.
- With HAZ_FWD_EN, the load is then forwarded. Without it, raw keeps stalling until the load has left mem_slot.
- Register 0 never causes a hazard.
- Reset asserted mid-stall: every slot clears immediately and outputs drop to 0 asynchronously.

Optional Feature:
- Macro: HAZ_FWD_EN.
- Defined:
  - raw term removed; only lduse, branch and memwait stall.
  - Adds outputs fwd_a and fwd_b, 2 bits each: 00 regfile, 01 from EX/MEM, 10 from MEM/WB.
  - fwd_a/fwd_b are registered for the instruction entering EX, captured when stall_D=0 and freeze=0.
  - EX-slot match takes priority over MEM-slot match.
- Undefined:
  - No forwarding ports.
  - Any RAW against the EX or MEM slot stalls until the writer has left MEM.

Test Plan:
- Reset then idle: rst_n=0 -> 1 with D_valid=0 -> all controls 0, stall_cnt=0, hz_state=0.
- Load-use:
  - Issue ld x5 (D_ld=1, D_rd=5), next cycle add reading rs1=5.
  - Response: stall_D=stall_F=hold_D=1 for exactly 1 cycle with HAZ_FWD_EN; hz_state=1 the cycle after; stall_cnt=1.
- Branch beats load-use:
  - Load-use condition and EX_brn_taken=1 in the same cycle.
  - Response: flush_D=1, stall_D=1, stall_F=0; hz_state=2 next; ex_slot becomes a bubble.
- Memory wait:
  - Store in MEM with mem_ready=0 for 3 cycles, then 1.
  - Response: freeze=stall_F=hold_D=1 for 3 cycles, stall_D=0, stall_cnt+=3; the scoreboard slots are unchanged after release.
- x0 and no-use:
  - Writer rd=0 followed by a reader of rs1=0 -> no stall.
  - Writer rd=7 followed by D_use_rs1=0 with rs1=7 -> no stall.
- RAW without forwarding:
  - Macro undefined; add x3, then a reader of rs2=3.
  - Response: stall_D=1 for 2 cycles, first against the EX slot and then the MEM slot; the reader issues on cycle 3.
